// File: rtl/sram_arbiter_if.sv
// Memory handshake bundle: valid/ready with byte strobes (wstrb == 0 means read).
// The arbiter faces each requesting master through the slave modport and drives
// the SRAM through the master modport, where valid acts as the SRAM select.
interface sram_arbiter_if #(
    parameter int ADDRWIDTH = 13
);
    logic                 valid;
    logic                 ready;
    logic [3:0]           wstrb;
    logic [ADDRWIDTH-1:0] addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;

    modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
    modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two masters.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; a watchdog force-completes
// a WAIT that sees no sram ready within TIMEOUT cycles.
module sram_arbiter #(
    parameter int ADDRWIDTH = 13,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sram_arbiter_if.slave         m0,
    sram_arbiter_if.slave         m1,
    sram_arbiter_if.master        sram,
    output logic                  timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    // Counter is 8 bits wide; the last WAIT cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 last_q;      // 1: master 1 was granted last
    logic                 owner_q;     // master owning the current access
    logic                 tmo_q;
    logic [7:0]           cnt_q;
    logic [3:0]           wstrb_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata0_q, rdata1_q;

    logic req, gnt1, tmo_hit;
    logic sel, rdy0, rdy1;

    // m1 wins when it is the only requester or when m0 held the last grant.
    assign req     = m0.valid | m1.valid;
    assign gnt1    = m1.valid & (~m0.valid | ~last_q);
    assign tmo_hit = ~sram.ready & (cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; requests are only sampled in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sram.ready || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: select in ISSUE, owner's ready in RESP
    always_comb begin
        sel  = 1'b0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        case (state_q)
            ISSUE:   sel = 1'b1;
            RESP: begin
                rdy0 = ~owner_q;
                rdy1 = owner_q;
            end
            default: ;
        endcase
    end

    // Datapath: latch the granted request, run the watchdog, capture read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    owner_q <= gnt1;
                    last_q  <= gnt1;
                    addr_q  <= gnt1 ? m1.addr  : m0.addr;
                    wstrb_q <= gnt1 ? m1.wstrb : m0.wstrb;
                    wdata_q <= gnt1 ? m1.wdata : m0.wdata;
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    if (sram.ready) begin
                        // Writes return zero rather than whatever the SRAM drives.
                        if (owner_q) rdata1_q <= (wstrb_q == 4'b0) ? sram.rdata : 32'h0;
                        else         rdata0_q <= (wstrb_q == 4'b0) ? sram.rdata : 32'h0;
                    end else if (tmo_hit) begin
                        tmo_q <= 1'b1;
                        if (owner_q) rdata1_q <= 32'hDEADBEEF;
                        else         rdata0_q <= 32'hDEADBEEF;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sram.valid  = sel;
    assign sram.addr   = addr_q;
    assign sram.wstrb  = wstrb_q;
    assign sram.wdata  = wdata_q;
    assign m0.ready    = rdy0;
    assign m1.ready    = rdy1;
    assign m0.rdata    = rdata0_q;
    assign m1.rdata    = rdata1_q;
    assign timeout_err = tmo_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a cycle table for single accesses, then
// hand sequences for contention, watchdog timeout, reset mid-access and late arrival.
module tb_sram_arbiter;
    localparam int AW  = 13;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic timeout_err;
    logic sram_en = 1'b1;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDRWIDTH(AW)) m0_if ();
    sram_arbiter_if #(.ADDRWIDTH(AW)) m1_if ();
    sram_arbiter_if #(.ADDRWIDTH(AW)) sram_if ();

    sram_arbiter #(.ADDRWIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
        .sram(sram_if), .timeout_err(timeout_err)
    );

    // SRAM model: one-cycle ready after select, byte-strobed writes, preloaded on reset
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (!reset_n) begin
            sram_if.ready <= 1'b0;
            sram_if.rdata <= 32'h0;
            mem[4] <= 32'h12345678;
            mem[1] <= 32'h11223344;
            mem[8] <= 32'hA0A0A0A0;
            mem[9] <= 32'hB1B1B1B1;
        end else begin
            sram_if.ready <= sram_if.valid & sram_en;
            if (sram_if.valid) begin
                sram_if.rdata <= mem[sram_if.addr[AW-1:2]];
                for (int b = 0; b < 4; b++)
                    if (sram_if.wstrb[b]) mem[sram_if.addr[AW-1:2]][b*8 +: 8] <= sram_if.wdata[b*8 +: 8];
            end
        end
    end

    typedef struct {
        logic m0v; logic [3:0] m0w; logic [AW-1:0] m0a; logic [31:0] m0d;
        logic m1v; logic [3:0] m1w; logic [AW-1:0] m1a; logic [31:0] m1d;
        logic sel; logic [AW-1:0] sa; logic [3:0] sw; logic [31:0] sd;
        logic r0; logic [31:0] rd0; logic r1; logic [31:0] rd1; logic tmo;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] w1, input logic [AW-1:0] a1, input logic [31:0] d1);
        m0_if.valid = v0; m0_if.wstrb = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.valid = v1; m1_if.wstrb = w1; m1_if.addr = a1; m1_if.wdata = d1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".sel"},   32'(sram_if.valid), 0);
        chk({nm, ".saddr"}, 32'(sram_if.addr), 0);
        chk({nm, ".swstrb"},32'(sram_if.wstrb), 0);
        chk({nm, ".swdata"},sram_if.wdata, 0);
        chk({nm, ".r0"},    32'(m0_if.ready), 0);
        chk({nm, ".rd0"},   m0_if.rdata, 0);
        chk({nm, ".r1"},    32'(m1_if.ready), 0);
        chk({nm, ".rd1"},   m1_if.rdata, 0);
        chk({nm, ".tmo"},   32'(timeout_err), 0);
    endtask

    vec_t vecs [15];

    initial begin
        int seq[$];
        int t0[$];
        int t1[$];
        int c;

        // m0 read 0x10; m1 byte write 0x04; m0 read-back of 0x04 (byte1 now AB)
        vecs[0]  = '{1,0,'h10,0, 0,0,0,0,        0,'h00,0,0,       0,32'h0,0,0,0};
        vecs[1]  = '{1,0,'h10,0, 0,0,0,0,        1,'h10,0,0,       0,32'h0,0,0,0};
        vecs[2]  = '{1,0,'h10,0, 0,0,0,0,        0,'h10,0,0,       0,32'h0,0,0,0};
        vecs[3]  = '{1,0,'h10,0, 0,0,0,0,        0,'h10,0,0,       1,32'h12345678,0,0,0};
        vecs[4]  = '{0,0,0,0,    0,0,0,0,        0,'h10,0,0,       0,32'h12345678,0,0,0};
        vecs[5]  = '{0,0,0,0,    1,2,'h4,'hAB00, 0,'h10,0,0,       0,32'h12345678,0,0,0};
        vecs[6]  = '{0,0,0,0,    1,2,'h4,'hAB00, 1,'h04,2,'hAB00,  0,32'h12345678,0,0,0};
        vecs[7]  = '{0,0,0,0,    1,2,'h4,'hAB00, 0,'h04,2,'hAB00,  0,32'h12345678,0,0,0};
        vecs[8]  = '{0,0,0,0,    1,2,'h4,'hAB00, 0,'h04,2,'hAB00,  0,32'h12345678,1,0,0};
        vecs[9]  = '{0,0,0,0,    0,0,0,0,        0,'h04,2,'hAB00,  0,32'h12345678,0,0,0};
        vecs[10] = '{1,0,'h4,0,  0,0,0,0,        0,'h04,2,'hAB00,  0,32'h12345678,0,0,0};
        vecs[11] = '{1,0,'h4,0,  0,0,0,0,        1,'h04,0,0,       0,32'h12345678,0,0,0};
        vecs[12] = '{1,0,'h4,0,  0,0,0,0,        0,'h04,0,0,       0,32'h12345678,0,0,0};
        vecs[13] = '{1,0,'h4,0,  0,0,0,0,        0,'h04,0,0,       1,32'h1122AB44,0,0,0};
        vecs[14] = '{0,0,0,0,    0,0,0,0,        0,'h04,0,0,       0,32'h1122AB44,0,0,0};

        drive(0,0,0,0, 0,0,0,0);
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].m0v, vecs[i].m0w, vecs[i].m0a, vecs[i].m0d,
                  vecs[i].m1v, vecs[i].m1w, vecs[i].m1a, vecs[i].m1d);
            #1;
            chk($sformatf("v%0d.sel", i),    32'(sram_if.valid), 32'(vecs[i].sel));
            chk($sformatf("v%0d.saddr", i),  32'(sram_if.addr),  32'(vecs[i].sa));
            chk($sformatf("v%0d.swstrb", i), 32'(sram_if.wstrb), 32'(vecs[i].sw));
            chk($sformatf("v%0d.swdata", i), sram_if.wdata,      vecs[i].sd);
            chk($sformatf("v%0d.r0", i),     32'(m0_if.ready),   32'(vecs[i].r0));
            chk($sformatf("v%0d.rd0", i),    m0_if.rdata,        vecs[i].rd0);
            chk($sformatf("v%0d.r1", i),     32'(m1_if.ready),   32'(vecs[i].r1));
            chk($sformatf("v%0d.rd1", i),    m1_if.rdata,        vecs[i].rd1);
            chk($sformatf("v%0d.tmo", i),    32'(timeout_err),   32'(vecs[i].tmo));
            @(negedge clk);
        end

        // Contention after reset: m0 must win the first tie, then strict alternation
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(1,0,'h20,0, 1,0,'h24,0);
        for (int cy = 0; cy < 80 && seq.size() < 8; cy++) begin
            #1;
            chk("cont.dual_ready", 32'(m0_if.ready & m1_if.ready), 0);
            chk("cont.ready_sel", 32'((m0_if.ready | m1_if.ready) & sram_if.valid), 0);
            if (m0_if.ready) begin
                seq.push_back(0); t0.push_back(cy);
                chk("cont.rd0", m0_if.rdata, 32'hA0A0A0A0);
            end
            if (m1_if.ready) begin
                seq.push_back(1); t1.push_back(cy);
                chk("cont.rd1", m1_if.rdata, 32'hB1B1B1B1);
            end
            @(negedge clk);
        end
        drive(0,0,0,0, 0,0,0,0);
        chk("cont.count", seq.size(), 8);
        for (int k = 0; k < seq.size(); k++) chk($sformatf("cont.order%0d", k), seq[k], k % 2);
        if (t0.size() > 0) chk("cont.first_m0", t0[0], 3);
        for (int k = 1; k < t0.size(); k++) chk($sformatf("cont.m0gap%0d", k), t0[k] - t0[k-1], 8);
        for (int k = 1; k < t1.size(); k++) chk($sformatf("cont.m1gap%0d", k), t1[k] - t1[k-1], 8);
        repeat (2) @(negedge clk);

        // Watchdog: SRAM never answers; ISSUE + 15 WAIT cycles then RESP with the error pulse
        sram_en = 1'b0;
        drive(1,0,'h10,0, 0,0,0,0);
        c = 0;
        for (int cy = 0; cy < 40; cy++) begin
            #1;
            c = cy;
            chk($sformatf("tmo.err_c%0d", cy), 32'(timeout_err), 32'(m0_if.ready));
            if (m0_if.ready) break;
            @(negedge clk);
        end
        chk("tmo.cycle", c, 17);
        chk("tmo.ready", 32'(m0_if.ready), 1);
        chk("tmo.rdata", m0_if.rdata, 32'hDEADBEEF);
        chk("tmo.r1", 32'(m1_if.ready), 0);
        drive(0,0,0,0, 0,0,0,0);
        @(negedge clk); #1;
        chk("tmo.idle_err", 32'(timeout_err), 0);
        chk("tmo.idle_r0", 32'(m0_if.ready), 0);
        sram_en = 1'b1;
        @(negedge clk);

        // Reset during WAIT: everything clears at once, pending request re-granted from scratch
        drive(1,0,'h10,0, 0,0,0,0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rmid");
        for (int cy = 0; cy < 2; cy++) begin
            @(negedge clk); #1;
            chk("rmid.hold_r0", 32'(m0_if.ready), 0);
        end
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("rmid.sel_c1", 32'(sram_if.valid), 1);
        chk("rmid.addr_c1", 32'(sram_if.addr), 32'h10);
        @(negedge clk); #1;
        chk("rmid.r0_c2", 32'(m0_if.ready), 0);
        @(negedge clk); #1;
        chk("rmid.r0_c3", 32'(m0_if.ready), 1);
        chk("rmid.rd0_c3", m0_if.rdata, 32'h12345678);
        drive(0,0,0,0, 0,0,0,0);
        @(negedge clk);

        // Late arrival: m1 raises valid while m0 is in WAIT, served only after m0 RESP + IDLE
        drive(1,0,'h20,0, 0,0,0,0);
        @(negedge clk); #1;
        chk("late.sel_c1", 32'(sram_if.valid), 1);
        @(negedge clk);
        drive(1,0,'h20,0, 1,0,'h24,0);
        @(negedge clk); #1;
        chk("late.r0_c3", 32'(m0_if.ready), 1);
        chk("late.rd0_c3", m0_if.rdata, 32'hA0A0A0A0);
        chk("late.sel_c3", 32'(sram_if.valid), 0);
        drive(0,0,0,0, 1,0,'h24,0);
        @(negedge clk); #1;
        chk("late.sel_c4", 32'(sram_if.valid), 0);
        chk("late.r1_c4", 32'(m1_if.ready), 0);
        @(negedge clk); #1;
        chk("late.sel_c5", 32'(sram_if.valid), 1);
        chk("late.addr_c5", 32'(sram_if.addr), 32'h24);
        @(negedge clk); #1;
        chk("late.r1_c6", 32'(m1_if.ready), 0);
        @(negedge clk); #1;
        chk("late.r1_c7", 32'(m1_if.ready), 1);
        chk("late.rd1_c7", m1_if.rdata, 32'hB1B1B1B1);
        drive(0,0,0,0, 0,0,0,0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
